// File: rtl/mcpu_ext_regs_pkg.sv
// Shared constants and helpers for the MCPU external register responder.
package mcpu_ext_regs_pkg;

    // Status word bit positions (J read)
    localparam int ST_RX_EMPTY     = 0;
    localparam int ST_RX_FULL      = 1;
    localparam int ST_TX_EMPTY     = 2;
    localparam int ST_TX_FULL      = 3;
    localparam int ST_RX_UNDERFLOW = 4;
    localparam int ST_TX_OVERFLOW  = 5;
    localparam int ST_RX_COUNT_LSB = 8;
    localparam int ST_TX_COUNT_LSB = 16;

    // Control word bit positions (J write)
    localparam int CTL_FLUSH_RX    = 0;
    localparam int CTL_FLUSH_TX    = 1;
    localparam int CTL_CLR_STICKY  = 2;

    // Strobe bit positions shared by regs_ext_re / regs_ext_we
    localparam int REG_I = 0;
    localparam int REG_J = 1;
    localparam int REG_K = 2;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_I,
        SEL_J,
        SEL_K
    } reg_sel_e;

    // Read strobe decode with I > J > K priority
    function automatic reg_sel_e decode_read_sel(input logic [2:0] re);
        reg_sel_e sel;
        sel = SEL_NONE;
        if (re[REG_I])      sel = SEL_I;
        else if (re[REG_J]) sel = SEL_J;
        else if (re[REG_K]) sel = SEL_K;
        return sel;
    endfunction

endpackage

// File: rtl/mcpu_sync_fifo.sv
// Single-clock FIFO with CW-bit wrap pointers, registered full/empty and
// a flush that overrides any same-cycle push. Storage is never reset.
module mcpu_sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    localparam int AW        = $clog2(DEPTH),
    localparam int CW        = AW + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [CW-1:0]         count_o,
    output logic [DATA_WIDTH-1:0] head_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]         wr_q, wr_d, rd_q, rd_d;
    logic                  full_q, full_d, empty_q, empty_d;
    logic                  do_push, do_pop;

    // Next pointers; a pop frees a slot so a push into a full FIFO is allowed
    always_comb begin
        do_pop  = pop_i && !empty_q && !flush_i;
        do_push = push_i && (!full_q || do_pop) && !flush_i;
        wr_d    = wr_q;
        rd_d    = rd_q;
        if (flush_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pop)  rd_d = rd_q + 1'b1;
        end
        empty_d = (wr_d == rd_d);
        full_d  = (wr_d[AW-1:0] == rd_d[AW-1:0]) && (wr_d[AW] != rd_d[AW]);
    end

    // Pointer and flag state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q    <= '0;
            rd_q    <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Storage write, deliberately without reset
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= push_data_i;
    end

    assign head_o  = mem_q[rd_q[AW-1:0]];
    assign count_o = wr_q - rd_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/mcpu_ext_regs.sv
// MCPU external register responder: I = RX/TX mailboxes, J = status/control,
// K = loadable free-running cycle counter, answered on the shared data_bus.
module mcpu_ext_regs #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            regs_ext_re,
    input  logic [2:0]            regs_ext_we,
    inout  wire  [DATA_WIDTH-1:0] data_bus,
    input  logic [DATA_WIDTH-1:0] host_in_data,
    input  logic                  host_in_valid,
    output logic                  host_in_ready,
    output logic [DATA_WIDTH-1:0] host_out_data,
    output logic                  host_out_valid,
    input  logic                  host_out_ready
);

    import mcpu_ext_regs_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    reg_sel_e              sel;
    logic [DATA_WIDTH-1:0] rd_data, status;
    logic                  rx_full, rx_empty, tx_full, tx_empty;
    logic [CW-1:0]         rx_count, tx_count;
    logic [DATA_WIDTH-1:0] rx_head, tx_head;
    logic                  rx_push, rx_pop, tx_push, tx_pop;
    logic                  flush_rx, flush_tx, clr_sticky;
    logic                  set_uf, set_of;
    logic                  uf_q, uf_d, of_q, of_d;
    logic [DATA_WIDTH-1:0] cnt_q, cnt_d;

    assign sel = decode_read_sel(regs_ext_re);

    // Status word assembled from pre-edge state
    always_comb begin
        status                          = '0;
        status[ST_RX_EMPTY]             = rx_empty;
        status[ST_RX_FULL]              = rx_full;
        status[ST_TX_EMPTY]             = tx_empty;
        status[ST_TX_FULL]              = tx_full;
        status[ST_RX_UNDERFLOW]         = uf_q;
        status[ST_TX_OVERFLOW]          = of_q;
        status[ST_RX_COUNT_LSB +: CW]   = rx_count;
        status[ST_TX_COUNT_LSB +: CW]   = tx_count;
    end

    // Combinational read mux; an empty RX reads as zero
    always_comb begin
        rd_data = '0;
        case (sel)
            SEL_I:   rd_data = rx_empty ? '0 : rx_head;
            SEL_J:   rd_data = status;
            SEL_K:   rd_data = cnt_q;
            default: rd_data = '0;
        endcase
    end

    // Bus is released immediately while reset is asserted
    assign data_bus = (reset && sel != SEL_NONE) ? rd_data : {DATA_WIDTH{1'bz}};

    assign host_in_ready  = !rx_full;
    assign host_out_valid = !tx_empty;
    assign host_out_data  = tx_empty ? '0 : tx_head;

    assign rx_push    = host_in_valid && host_in_ready;
    assign rx_pop     = (sel == SEL_I);
    assign tx_push    = regs_ext_we[REG_I];
    assign tx_pop     = host_out_valid && host_out_ready;
    assign flush_rx   = regs_ext_we[REG_J] && data_bus[CTL_FLUSH_RX];
    assign flush_tx   = regs_ext_we[REG_J] && data_bus[CTL_FLUSH_TX];
    assign clr_sticky = regs_ext_we[REG_J] && data_bus[CTL_CLR_STICKY];
    assign set_uf     = rx_pop && rx_empty;
    assign set_of     = tx_push && tx_full && !tx_pop;

    // Sticky flags keep a fresh event even when cleared in the same cycle
    always_comb begin
        uf_d  = set_uf || (uf_q && !clr_sticky);
        of_d  = set_of || (of_q && !clr_sticky);
        cnt_d = regs_ext_we[REG_K] ? data_bus : cnt_q + 1'b1;
    end

    // Sticky flags and cycle counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            uf_q  <= 1'b0;
            of_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            uf_q  <= uf_d;
            of_q  <= of_d;
            cnt_q <= cnt_d;
        end
    end

    mcpu_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
        .clk_i       (clk),
        .rst_ni      (reset),
        .push_i      (rx_push),
        .push_data_i (host_in_data),
        .pop_i       (rx_pop),
        .flush_i     (flush_rx),
        .full_o      (rx_full),
        .empty_o     (rx_empty),
        .count_o     (rx_count),
        .head_o      (rx_head)
    );

    mcpu_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
        .clk_i       (clk),
        .rst_ni      (reset),
        .push_i      (tx_push),
        .push_data_i (data_bus),
        .pop_i       (tx_pop),
        .flush_i     (flush_tx),
        .full_o      (tx_full),
        .empty_o     (tx_empty),
        .count_o     (tx_count),
        .head_o      (tx_head)
    );

endmodule

// File: tb/tb_mcpu_ext_regs.sv
// Directed bench for mcpu_ext_regs with hand-computed expected values.
module tb_mcpu_ext_regs;

    localparam int DW    = 32;
    localparam int DEPTH = 8;

    logic          clk;
    logic          reset;
    logic [2:0]    re, we;
    logic [DW-1:0] bus_drv;
    logic          bus_en;
    wire  [DW-1:0] data_bus;
    logic [DW-1:0] hin_data;
    logic          hin_valid;
    logic          hin_ready;
    logic [DW-1:0] hout_data;
    logic          hout_valid;
    logic          hout_ready;
    logic [DW-1:0] rv;

    int n_chk = 0;
    int n_err = 0;

    assign data_bus = bus_en ? bus_drv : {DW{1'bz}};

    mcpu_ext_regs #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .regs_ext_re    (re),
        .regs_ext_we    (we),
        .data_bus       (data_bus),
        .host_in_data   (hin_data),
        .host_in_valid  (hin_valid),
        .host_in_ready  (hin_ready),
        .host_out_data  (hout_data),
        .host_out_valid (hout_valid),
        .host_out_ready (hout_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One strobe cycle: sample the bus mid-cycle, then let the edge commit
    task automatic cpu_read(input int r, output logic [DW-1:0] v);
        re    = '0;
        re[r] = 1'b1;
        #2;
        v = data_bus;
        @(posedge clk);
        #1;
        re = '0;
    endtask

    task automatic cpu_write(input int r, input logic [DW-1:0] val);
        we      = '0;
        we[r]   = 1'b1;
        bus_en  = 1'b1;
        bus_drv = val;
        @(posedge clk);
        #1;
        we     = '0;
        bus_en = 1'b0;
    endtask

    task automatic host_push(input logic [DW-1:0] d);
        hin_valid = 1'b1;
        hin_data  = d;
        @(posedge clk);
        #1;
        hin_valid = 1'b0;
    endtask

    initial begin
        re = '0; we = '0; bus_en = 1'b0; bus_drv = '0;
        hin_data = '0; hin_valid = 1'b0; hout_ready = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        chk("rst_in_ready",   {31'b0, hin_ready},  32'h1);
        chk("rst_out_valid",  {31'b0, hout_valid}, 32'h0);
        chk("rst_out_data",   hout_data,           32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        cpu_read(2, rv); chk("rst_counter", rv, 32'h0);
        cpu_read(1, rv); chk("rst_status",  rv, 32'h5);

        // RX path and underflow
        host_push(32'h11);
        host_push(32'h22);
        cpu_read(0, rv); chk("rx_first",  rv, 32'h11);
        cpu_read(0, rv); chk("rx_second", rv, 32'h22);
        cpu_read(0, rv); chk("rx_empty_read", rv, 32'h0);
        cpu_read(1, rv); chk("rx_underflow_status", rv, 32'h15);
        cpu_write(1, 32'h4);
        cpu_read(1, rv); chk("sticky_clear", rv, 32'h5);

        // TX overflow and host drain
        for (int i = 0; i < 9; i++) cpu_write(0, DW'(i));
        cpu_read(1, rv); chk("tx_full_status", rv, 32'h0008_0029);
        chk("tx_valid_full", {31'b0, hout_valid}, 32'h1);
        hout_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #2;
            chk($sformatf("tx_drain_%0d", i), hout_data, DW'(i));
            @(posedge clk);
            #1;
        end
        hout_ready = 1'b0;
        chk("tx_valid_drained", {31'b0, hout_valid}, 32'h0);
        chk("tx_data_drained",  hout_data, 32'h0);
        cpu_read(1, rv); chk("tx_drained_status", rv, 32'h25);

        // Counter load and wrap
        cpu_write(2, 32'hFFFF_FFFE);
        cpu_read(2, rv); chk("cnt_load", rv, 32'hFFFF_FFFE);
        cpu_read(2, rv); chk("cnt_inc",  rv, 32'hFFFF_FFFF);
        cpu_read(2, rv); chk("cnt_wrap", rv, 32'h0);

        // Flush beats a same-cycle host push; sticky flags cleared
        cpu_read(0, rv); chk("uf_read", rv, 32'h0);
        cpu_read(1, rv); chk("both_sticky", rv, 32'h35);
        host_push(32'h33);
        cpu_read(1, rv); chk("rx_one_status", rv, 32'h134);
        hin_valid = 1'b1; hin_data = 32'h44;
        we = 3'b010; bus_en = 1'b1; bus_drv = 32'h7;
        @(posedge clk);
        #1;
        hin_valid = 1'b0; we = '0; bus_en = 1'b0;
        cpu_read(1, rv); chk("flush_status", rv, 32'h5);

        // Full RX: CPU pop while host holds valid
        for (int i = 0; i < 8; i++) host_push(32'h100 + DW'(i));
        chk("rx_full_ready", {31'b0, hin_ready}, 32'h0);
        cpu_read(1, rv); chk("rx_full_status", rv, 32'h806);
        hin_valid = 1'b1; hin_data = 32'h200;
        re = 3'b001;
        #2;
        chk("full_pop_data",  data_bus, 32'h100);
        chk("full_pop_ready", {31'b0, hin_ready}, 32'h0);
        @(posedge clk);
        #1;
        re = '0;
        chk("after_pop_ready", {31'b0, hin_ready}, 32'h1);
        cpu_read(1, rv); chk("count_7", rv, 32'h704);
        hin_valid = 1'b0;
        chk("refill_ready", {31'b0, hin_ready}, 32'h0);
        cpu_read(1, rv); chk("count_8", rv, 32'h806);

        // MOV I,I moves the RX head into TX
        re = 3'b001; we = 3'b001;
        @(posedge clk);
        #1;
        re = '0; we = '0;
        chk("mov_valid", {31'b0, hout_valid}, 32'h1);
        chk("mov_data",  hout_data, 32'h101);
        for (int i = 2; i < 8; i++) begin
            cpu_read(0, rv);
            chk($sformatf("rx_order_%0d", i), rv, 32'h100 + DW'(i));
        end
        cpu_read(0, rv); chk("rx_refill_word", rv, 32'h200);
        cpu_read(1, rv); chk("mov_status", rv, 32'h0001_0001);

        // Asynchronous reset with RX occupied and a read strobe active
        host_push(32'hF1);
        host_push(32'hF2);
        host_push(32'hF3);
        re = 3'b001;
        #2;
        chk("pre_rst_bus", data_bus, 32'hF1);
        reset  = 1'b0;
        bus_en = 1'b1;
        bus_drv = 32'h0;
        #1;
        chk("mid_rst_bus_released", data_bus, 32'h0);
        chk("mid_rst_in_ready",  {31'b0, hin_ready},  32'h1);
        chk("mid_rst_out_valid", {31'b0, hout_valid}, 32'h0);
        chk("mid_rst_out_data",  hout_data, 32'h0);
        re = '0; bus_en = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        cpu_read(1, rv); chk("post_rst_status", rv, 32'h5);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
